// File: rtl/mmio_ctrl_pkg.sv
// Shared MMIO constants for the Riscv151 0x8000_00xx window, plus the offset decoder.
// The core decode imports the same offsets, so both sides agree on the map.
package mmio_ctrl_pkg;

  localparam logic [31:0] MMIO_ADDR_BASE = 32'h8000_0000;

  localparam logic [4:0] MMIO_UART_CTRL = 5'h00;
  localparam logic [4:0] MMIO_UART_RX   = 5'h04;
  localparam logic [4:0] MMIO_UART_TX   = 5'h08;
  localparam logic [4:0] MMIO_CYC       = 5'h10;
  localparam logic [4:0] MMIO_INST      = 5'h14;
  localparam logic [4:0] MMIO_RST       = 5'h18;

  localparam int STAT_TX_NOT_FULL = 0;
  localparam int STAT_RX_FULL     = 1;
  localparam int STAT_OVF         = 2;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_STATUS,
    OP_RX,
    OP_TX,
    OP_CYC,
    OP_INST,
    OP_CLR
  } mmio_op_e;

  // Loads and stores share some offsets; a direction mismatch is treated as unmapped.
  function automatic mmio_op_e mmio_decode(input logic [4:0] off, input logic we);
    mmio_decode = OP_NONE;
    case (off)
      MMIO_UART_CTRL: if (!we) mmio_decode = OP_STATUS;
      MMIO_UART_RX:   if (!we) mmio_decode = OP_RX;
      MMIO_UART_TX:   if (we)  mmio_decode = OP_TX;
      MMIO_CYC:       if (!we) mmio_decode = OP_CYC;
      MMIO_INST:      if (!we) mmio_decode = OP_INST;
      MMIO_RST:       if (we)  mmio_decode = OP_CLR;
      default:        mmio_decode = OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_ctrl_tx_fifo.sv
// Synchronous TX byte FIFO with wrap-bit pointers; a push while full is accepted
// only when a pop frees the head slot in the same cycle.
module mmio_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries data only; validity is fully defined by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: decodes EX-stage accesses, feeds the UART through a TX FIFO,
// holds one RX byte, owns the cycle/instruction counters, returns loads one cycle later.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        instr_retire,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  logic        w_hit;
  mmio_op_e    w_op;
  logic        w_load;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_pop;
  logic        w_rx_capture;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic        w_cnt_clr;
  logic [31:0] w_rd_mux;

  logic        r_rx_full;
  logic [7:0]  r_rx_byte;
  logic        r_ovf;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;
  logic        r_rd_vld_p1;
  logic [31:0] r_rd_data_p1;

  assign w_hit  = (req_addr[31:5] == ADDR_BASE[31:5]);
  assign w_op   = (req_valid && w_hit) ? mmio_decode(req_addr[4:0], req_we) : OP_NONE;
  assign w_load = req_valid && !req_we;

  assign w_tx_push    = (w_op == OP_TX);
  assign w_tx_pop     = uart_tx_valid && uart_tx_ready;
  assign w_rx_pop     = (w_op == OP_RX) && r_rx_full;
  assign w_rx_capture = uart_rx_valid && uart_rx_ready;
  assign w_ovf_set    = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_ovf_clr    = (w_op == OP_STATUS);
  assign w_cnt_clr    = (w_op == OP_CLR);

  assign uart_tx_valid = !w_tx_empty;
  assign uart_rx_ready = !r_rx_full || w_rx_pop;

  mmio_tx_fifo #(
    .DEPTH  (TX_DEPTH),
    .DATA_W (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (req_wdata),
    .dout  (uart_tx_data),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  // A pop with a simultaneous arrival leaves the register full with the new byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_full <= 1'b0;
      r_rx_byte <= '0;
    end else if (w_rx_capture) begin
      r_rx_full <= 1'b1;
      r_rx_byte <= uart_rx_data;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (instr_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_op)
      OP_STATUS: begin
        w_rd_mux[STAT_TX_NOT_FULL] = !w_tx_full;
        w_rd_mux[STAT_RX_FULL]     = r_rx_full;
        w_rd_mux[STAT_OVF]         = r_ovf;
      end
      OP_RX:   w_rd_mux = r_rx_full ? {24'b0, r_rx_byte} : 32'b0;
      OP_CYC:  w_rd_mux = r_cycle_cnt;
      OP_INST: w_rd_mux = r_instr_cnt;
      default: w_rd_mux = '0;
    endcase
  end

  // ---- EX -> MEM/WB boundary: load result registered alongside its valid ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_data_p1 <= '0;
    end else begin
      r_rd_vld_p1 <= w_load;
      if (w_load) r_rd_data_p1 <= w_rd_mux;
    end
  end

  assign rd_valid = r_rd_vld_p1;
  assign rd_data  = r_rd_data_p1;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl: reset, TX FIFO, overflow, RX holding,
// counters, wrap and unmapped accesses.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        instr_retire;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_ctrl #(
    .TX_DEPTH  (8),
    .ADDR_BASE (32'h8000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .instr_retire  (instr_retire),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [7:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    step();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0 || uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd_valid=%b rd_data=%h tx_valid=%b rx_ready=%b, expected 0 0 0 1",
               rd_valid, rd_data, uart_tx_valid, uart_rx_ready);
    end
    rst_n = 1'b1;
    step();
    store(32'h8000_0008, 8'h01);
    store(32'h8000_0008, 8'h02);
    store(32'h8000_0008, 8'h03);
    n_checks++;
    if (uart_tx_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_txvalid: got %b, expected 1", uart_tx_valid);
    end
    load(32'h8000_0000);
    // rd_valid is now in flight; reset must discard it together with the queue
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (uart_tx_valid !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: got tx_valid=%b rd_valid=%b rd_data=%h, expected 0 0 0",
               uart_tx_valid, rd_valid, rd_data);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_cyc: got vld=%b data=%h, expected 1 00000000", rd_valid, rd_data);
    end
    req_addr = 32'h8000_0014;
    step();
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_inst: got %h, expected 00000000", rd_data);
    end
    req_addr = 32'h8000_0000;
    step();
    req_valid = 1'b0;
    n_checks++;
    if (rd_data !== 32'h1) begin
      n_fail++; $display("FAIL reset_status: got %h, expected 00000001", rd_data);
    end
  endtask

  task automatic test_tx();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h8000_0008, exp_b[i]);
    step();
    n_checks++;
    if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
      n_fail++; $display("FAIL tx_head: got vld=%b data=%h, expected 1 41", uart_tx_valid, uart_tx_data);
    end
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== exp_b[i]) begin
        n_fail++;
        $display("FAIL tx_order[%0d]: got vld=%b data=%h, expected 1 %h", i, uart_tx_valid, uart_tx_data, exp_b[i]);
      end
      step();
    end
    n_checks++;
    if (uart_tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL tx_drained: got %b, expected 0", uart_tx_valid);
    end
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(32'h8000_0008, 8'h10 + 8'(i));
    load(32'h8000_0000);
    n_checks++;
    if (rd_data !== 32'h4) begin
      n_fail++; $display("FAIL ovf_status1: got %h, expected 00000004", rd_data);
    end
    load(32'h8000_0000);
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL ovf_status2: got %h, expected 00000000", rd_data);
    end
    // push and pop together while full: byte accepted, no overflow
    uart_tx_ready = 1'b1;
    store(32'h8000_0008, 8'hAA);
    uart_tx_ready = 1'b0;
    load(32'h8000_0000);
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL full_pushpop_status: got %h, expected 00000000", rd_data);
    end
    uart_tx_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      n_checks++;
      if (uart_tx_data !== ((i == 8) ? 8'hAA : 8'h10 + 8'(i))) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: got %h, expected %h", i, uart_tx_data, (i == 8) ? 8'hAA : 8'h10 + 8'(i));
      end
      step();
    end
    n_checks++;
    if (uart_tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drained: got %b, expected 0", uart_tx_valid);
    end
    uart_tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
    step();
    uart_rx_valid = 1'b0;
    n_checks++;
    if (uart_rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL rx_ready_full: got %b, expected 0", uart_rx_ready);
    end
    load(32'h8000_0000);
    n_checks++;
    if (rd_data !== 32'h3) begin
      n_fail++; $display("FAIL rx_status_full: got %h, expected 00000003", rd_data);
    end
    load(32'h8000_0004);
    n_checks++;
    if (rd_data !== 32'h5A) begin
      n_fail++; $display("FAIL rx_byte: got %h, expected 0000005a", rd_data);
    end
    load(32'h8000_0000);
    n_checks++;
    if (rd_data !== 32'h1) begin
      n_fail++; $display("FAIL rx_status_empty: got %h, expected 00000001", rd_data);
    end
    uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
    step();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0004;
    uart_rx_data = 8'h33; uart_rx_valid = 1'b1;
    #1;
    n_checks++;
    if (uart_rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL rx_ready_on_pop: got %b, expected 1", uart_rx_ready);
    end
    step();
    req_valid = 1'b0; uart_rx_valid = 1'b0;
    n_checks++;
    if (rd_data !== 32'h5A) begin
      n_fail++; $display("FAIL rx_pop_arrive_old: got %h, expected 0000005a", rd_data);
    end
    load(32'h8000_0000);
    n_checks++;
    if (rd_data !== 32'h3) begin
      n_fail++; $display("FAIL rx_still_full: got %h, expected 00000003", rd_data);
    end
    load(32'h8000_0004);
    n_checks++;
    if (rd_data !== 32'h33) begin
      n_fail++; $display("FAIL rx_new_byte: got %h, expected 00000033", rd_data);
    end
    load(32'h8000_0004);
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL rx_empty_read: got %h, expected 00000000", rd_data);
    end
    load(32'h8000_0000);
    n_checks++;
    if (rd_data !== 32'h1) begin
      n_fail++; $display("FAIL rx_empty_nochange: got %h, expected 00000001", rd_data);
    end
  endtask

  task automatic test_counters();
    store(32'h8000_0018, 8'h00);
    for (int i = 0; i < 100; i++) begin
      instr_retire = (i < 40);
      step();
    end
    instr_retire = 1'b0;
    load(32'h8000_0010);
    n_checks++;
    if (rd_data !== 32'd100) begin
      n_fail++; $display("FAIL cnt_cycle: got %0d, expected 100", rd_data);
    end
    load(32'h8000_0014);
    n_checks++;
    if (rd_data !== 32'd40) begin
      n_fail++; $display("FAIL cnt_instr: got %0d, expected 40", rd_data);
    end
    instr_retire = 1'b1;
    store(32'h8000_0018, 8'h00);
    instr_retire = 1'b0;
    load(32'h8000_0010);
    n_checks++;
    if (rd_data !== 32'd0) begin
      n_fail++; $display("FAIL cnt_clr_cycle: got %0d, expected 0", rd_data);
    end
    load(32'h8000_0014);
    n_checks++;
    if (rd_data !== 32'd0) begin
      n_fail++; $display("FAIL cnt_clr_instr: got %0d, expected 0", rd_data);
    end
  endtask

  task automatic test_wrap();
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010;
    #2;
    release dut.r_cycle_cnt;
    step();
    n_checks++;
    if (rd_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_pre: got %h, expected ffffffff", rd_data);
    end
    step();
    req_valid = 1'b0;
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL wrap_zero: got %h, expected 00000000", rd_data);
    end
    load(32'h8000_0010);
    load(32'h8000_001C);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_load: got vld=%b data=%h, expected 1 00000000", rd_valid, rd_data);
    end
    load(32'h8000_0010);
    load(32'h9000_0010);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL outside_load: got vld=%b data=%h, expected 1 00000000", rd_valid, rd_data);
    end
    store(32'h9000_0008, 8'h77);
    n_checks++;
    if (rd_valid !== 1'b0 || uart_tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL outside_store: got rd_valid=%b tx_valid=%b, expected 0 0", rd_valid, uart_tx_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    instr_retire = 1'b0; uart_tx_ready = 1'b0;
    uart_rx_data = '0; uart_rx_valid = 1'b0;
    step();
    step();
    test_reset();
    test_tx();
    test_overflow();
    test_rx();
    test_counters();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
